// File: rtl/intr_ctrl.sv
// intr_ctrl - interrupt front end for the single-cycle cpu.
//
// Purpose:
//   Two asynchronous request pins are synchronized. Their rising edges are
//   latched as pending requests. Source 2 can also be fed by an optional
//   periodic timer. Pending requests are delivered to the cpu as one-cycle
//   pulses with fixed priority, where source 1 wins. After each pulse the
//   controller waits HOLDOFF cycles before it can issue the next one.
//
// Parameters:
//   HOLDOFF       idle cycles forced after each pulse (1..255)
//   TIMER_PERIOD  timer period for source 2 in cycles; 0 disables (0..65535)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset, clears all state
//   irq_ext1  in   asynchronous request, source 1
//   irq_ext2  in   asynchronous request, source 2
//   en1       in   enable for source 1 (edges dropped when low)
//   en2       in   enable for source 2 (edges dropped, timer frozen when low)
//   intr1     out  registered one-cycle pulse to cpu.intr1
//   intr2     out  registered one-cycle pulse to cpu.intr2
//   pend      out  pending flags, bit 0 = source 1, bit 1 = source 2
//   ovf       out  sticky overrun flags, same mapping, cleared by reset only
//   busy      out  high during the HOLDOFF cycles that follow a pulse
module intr_ctrl #(
  parameter int HOLDOFF      = 8,
  parameter int TIMER_PERIOD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq_ext1,
  input  logic       irq_ext2,
  input  logic       en1,
  input  logic       en2,
  output logic       intr1,
  output logic       intr2,
  output logic [1:0] pend,
  output logic [1:0] ovf,
  output logic       busy
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF);

  // Synchronizer chain: s1/s2 resolve metastability, s3 is the edge delay.
  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] r_s3;
  logic [1:0] w_irq;
  logic [1:0] w_edge;
  logic       w_tick;
  logic [1:0] w_set;
  logic [1:0] w_clr;

  state_t     r_state;
  logic [7:0] r_hold;
  logic [1:0] r_pend;
  logic [1:0] r_ovf;
  logic       r_intr1;
  logic       r_intr2;
  logic       r_busy;

  assign w_irq = {irq_ext2, irq_ext1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 2'b00;
      r_s2 <= 2'b00;
      r_s3 <= 2'b00;
    end else begin
      r_s1 <= w_irq;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  // Optional periodic tick on source 2. The counter runs 0..TIMER_PERIOD-1.
  // It freezes while en2 is low, so a disabled window delays later ticks
  // instead of dropping them.
  generate
    if (TIMER_PERIOD > 0) begin : g_timer
      localparam logic [15:0] TCNT_LAST = 16'(TIMER_PERIOD - 1);
      logic [15:0] r_tcnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_tcnt <= 16'd0;
        end else if (en2) begin
          r_tcnt <= (r_tcnt == TCNT_LAST) ? 16'd0 : r_tcnt + 16'd1;
        end
      end

      assign w_tick = en2 && (r_tcnt == TCNT_LAST);
    end else begin : g_no_timer
      assign w_tick = 1'b0;
    end
  endgenerate

  assign w_set = {w_edge[1] | w_tick, w_edge[0]} & {en2, en1};

  // Source chosen for service this cycle. It is only non-zero in IDLE, and
  // source 1 has priority.
  always_comb begin
    w_clr = 2'b00;
    if (r_state == S_IDLE) begin
      if (r_pend[0]) begin
        w_clr = 2'b01;
      end else if (r_pend[1]) begin
        w_clr = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hold  <= 8'd0;
      r_pend  <= 2'b00;
      r_ovf   <= 2'b00;
      r_intr1 <= 1'b0;
      r_intr2 <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // If a new edge arrives on the cycle its bit is serviced, the new edge
      // wins. That case is a fresh request, not an overrun.
      r_pend  <= w_set | (r_pend & ~w_clr);
      r_ovf   <= r_ovf | (w_set & r_pend & ~w_clr);
      r_intr1 <= w_clr[0];
      r_intr2 <= w_clr[1];
      // busy lags the state by one cycle. It therefore covers the HOLDOFF
      // cycles after the pulse and is low during the pulse itself.
      r_busy  <= (r_state == S_HOLD);
      case (r_state)
        S_IDLE: begin
          if (r_pend != 2'b00) begin
            r_hold  <= HOLD_INIT;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_hold == 8'd1) begin
            r_state <= S_IDLE;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign intr1 = r_intr1;
  assign intr2 = r_intr2;
  assign pend  = r_pend;
  assign ovf   = r_ovf;
  assign busy  = r_busy;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: HOLDOFF=8, no timer. DUT B: HOLDOFF=4, timer period 20.
  logic       a_reset, a_irq1, a_irq2, a_en1, a_en2;
  logic       a_intr1, a_intr2, a_busy;
  logic [1:0] a_pend, a_ovf;
  logic       b_reset, b_irq1, b_irq2, b_en1, b_en2;
  logic       b_intr1, b_intr2, b_busy;
  logic [1:0] b_pend, b_ovf;

  intr_ctrl #(.HOLDOFF(8), .TIMER_PERIOD(0)) dut_a (
    .clk(clk), .reset(a_reset), .irq_ext1(a_irq1), .irq_ext2(a_irq2),
    .en1(a_en1), .en2(a_en2), .intr1(a_intr1), .intr2(a_intr2),
    .pend(a_pend), .ovf(a_ovf), .busy(a_busy)
  );

  intr_ctrl #(.HOLDOFF(4), .TIMER_PERIOD(20)) dut_b (
    .clk(clk), .reset(b_reset), .irq_ext1(b_irq1), .irq_ext2(b_irq2),
    .en1(b_en1), .en2(b_en2), .intr1(b_intr1), .intr2(b_intr2),
    .pend(b_pend), .ovf(b_ovf), .busy(b_busy)
  );

  typedef struct {
    int         cyc;
    logic [1:0] bits;   // {intr2, intr1}
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic push_a(input int c, input logic [1:0] b);
    exp_t e;
    e.cyc  = c;
    e.bits = b;
    qa.push_back(e);
  endtask

  task automatic push_b(input int c, input logic [1:0] b);
    exp_t e;
    e.cyc  = c;
    e.bits = b;
    qb.push_back(e);
  endtask

  // One clock cycle. Outputs are sampled on the falling edge, and the
  // scoreboards are matched against any interrupt pulses seen there.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    $display("cyc=%0d A: intr=%b%b pend=%b ovf=%b busy=%b | B: intr=%b%b pend=%b busy=%b",
             cyc, a_intr2, a_intr1, a_pend, a_ovf, a_busy, b_intr2, b_intr1, b_pend, b_busy);
    if (qa.size() != 0 && qa[0].cyc == cyc) begin
      e = qa.pop_front();
      checks++;
      assert ({a_intr2, a_intr1} === e.bits) else begin
        failures++;
        $error("FAIL a_pulse cyc=%0d observed=%b expected=%b", cyc, {a_intr2, a_intr1}, e.bits);
      end
    end else if (a_intr1 === 1'b1 || a_intr2 === 1'b1) begin
      checks++;
      assert ({a_intr2, a_intr1} === 2'b00) else begin
        failures++;
        $error("FAIL a_unexpected cyc=%0d observed=%b expected=00", cyc, {a_intr2, a_intr1});
      end
    end
    if (qb.size() != 0 && qb[0].cyc == cyc) begin
      e = qb.pop_front();
      checks++;
      assert ({b_intr2, b_intr1} === e.bits) else begin
        failures++;
        $error("FAIL b_pulse cyc=%0d observed=%b expected=%b", cyc, {b_intr2, b_intr1}, e.bits);
      end
    end else if (b_intr1 === 1'b1 || b_intr2 === 1'b1) begin
      checks++;
      assert ({b_intr2, b_intr1} === 2'b00) else begin
        failures++;
        $error("FAIL b_unexpected cyc=%0d observed=%b expected=00", cyc, {b_intr2, b_intr1});
      end
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    int c;
    int r;
    a_reset = 1'b1; a_irq1 = 1'b0; a_irq2 = 1'b0; a_en1 = 1'b1; a_en2 = 1'b1;
    b_reset = 1'b1; b_irq1 = 1'b0; b_irq2 = 1'b0; b_en1 = 1'b1; b_en2 = 1'b1;
    steps(3);

    // Reset state
    chk("a_rst_out",  32'({a_intr2, a_intr1, a_busy}), 0);
    chk("a_rst_pend", 32'(a_pend), 0);
    chk("a_rst_ovf",  32'(a_ovf), 0);
    chk("b_rst_out",  32'({b_intr2, b_intr1, b_busy}), 0);
    chk("b_rst_pend", 32'(b_pend), 0);
    a_reset = 1'b0;
    steps(3);

    // Single request: pin rises before edge c+1, pend at c+3, pulse at c+4
    c = cyc;
    a_irq1 = 1'b1;
    push_a(c + 4, 2'b01);
    steps(2);
    chk("t1_pend_early", 32'(a_pend), 0);
    step();
    chk("t1_pend_set", 32'(a_pend), 1);
    step();
    chk("t1_pend_clr", 32'(a_pend), 0);
    chk("t1_busy_at_pulse", 32'(a_busy), 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("t1_busy", 32'(a_busy), 1);
    end
    step();
    chk("t1_busy_end", 32'(a_busy), 0);
    steps(10);
    a_irq1 = 1'b0;
    steps(5);

    // Simultaneous requests: source 1 at t, source 2 at t+9
    c = cyc;
    a_irq1 = 1'b1;
    a_irq2 = 1'b1;
    push_a(c + 4, 2'b01);
    push_a(c + 13, 2'b10);
    steps(20);
    a_irq1 = 1'b0;
    a_irq2 = 1'b0;
    steps(5);
    chk("t2_pend", 32'(a_pend), 0);
    chk("t2_ovf", 32'(a_ovf), 0);

    // Overrun: edges land at c+5 (fresh), c+8 and c+11 (overrun), all during HOLD
    c = cyc;
    push_a(c + 4, 2'b01);
    push_a(c + 13, 2'b01);
    a_irq1 = 1'b1; step(); a_irq1 = 1'b0; step();
    a_irq1 = 1'b1; step(); a_irq1 = 1'b0; steps(2);
    a_irq1 = 1'b1; step(); a_irq1 = 1'b0; steps(2);
    a_irq1 = 1'b1; step(); a_irq1 = 1'b0;
    chk("t3_ovf_set", 32'(a_ovf), 1);
    chk("t3_pend_held", 32'(a_pend), 1);
    steps(25);
    chk("t3_ovf_sticky", 32'(a_ovf), 1);
    chk("t3_pend_clear", 32'(a_pend), 0);

    // Disabled source 2
    a_en2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_irq2 = 1'b1; step();
      a_irq2 = 1'b0; steps(2);
    end
    steps(4);
    chk("t4_pend1_off", 32'(a_pend[1]), 0);
    chk("t4_ovf1_off", 32'(a_ovf[1]), 0);
    a_en2 = 1'b1;
    steps(12);
    chk("t4_no_stale", 32'(a_pend), 0);

    // Reset during HOLD with pend=10
    c = cyc;
    a_irq1 = 1'b1;
    a_irq2 = 1'b1;
    push_a(c + 4, 2'b01);
    step();
    a_irq1 = 1'b0;
    a_irq2 = 1'b0;
    steps(5);
    chk("t6_pend_before", 32'(a_pend), 2);
    chk("t6_busy_before", 32'(a_busy), 1);
    a_reset = 1'b1;
    step();
    chk("t6_out_after", 32'({a_intr2, a_intr1, a_busy}), 0);
    chk("t6_pend_after", 32'(a_pend), 0);
    chk("t6_ovf_after", 32'(a_ovf), 0);
    a_reset = 1'b0;
    steps(20);
    chk("t6_quiet_pend", 32'(a_pend), 0);

    // Timer on DUT B: period 20, plus a 5-cycle en2 drop that delays later ticks
    chk("b_rst_hold", 32'(b_pend), 0);
    b_reset = 1'b0;
    r = cyc;
    push_b(r + 21, 2'b10);
    push_b(r + 41, 2'b10);
    push_b(r + 66, 2'b10);
    push_b(r + 86, 2'b10);
    steps(19);
    chk("b_pend_early", 32'(b_pend), 0);
    step();
    chk("b_pend_tick", 32'(b_pend), 2);
    step();
    chk("b_pend_clr", 32'(b_pend), 0);
    step();
    chk("b_busy", 32'(b_busy), 1);
    steps(28);
    b_en2 = 1'b0;
    steps(5);
    b_en2 = 1'b1;
    steps(35);
    b_en2 = 1'b0;
    steps(5);
    chk("b_ovf", 32'(b_ovf), 0);

    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller that sits directly upstream of the single-cycle `cpu` and drives its `intr1`/`intr2` inputs. It synchronizes two asynchronous external request lines, detects rising edges, and latches them as pending requests. It also holds an optional periodic timer tick on source 2. Pending requests go to the CPU as fixed-priority, one-cycle pulses, with a programmable hold-off so the CPU never sees back-to-back interrupts.

## Interface
Parameters:
- `HOLDOFF`, default 8: idle cycles forced after each pulse; legal range 1..255.
- `TIMER_PERIOD`, default 0: timer period in cycles for source 2; 0 disables the timer; legal range 0..65535.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `irq_ext1`  in  1  asynchronous external request, source 1.
- `irq_ext2`  in  1  asynchronous external request, source 2.
- `en1`  in  1  enable for source 1; when low, edges are dropped.
- `en2`  in  1  enable for source 2 (external edge and timer); when low, the timer is frozen.
- `intr1`  out  1  one-cycle interrupt pulse to `cpu`.`intr1`; registered.
- `intr2`  out  1  one-cycle interrupt pulse to `cpu`.`intr2`; registered.
- `pend`  out  2  pending flags; bit 0 is source 1, bit 1 is source 2.
- `ovf`  out  2  sticky overrun flags, same bit mapping; cleared only by `reset`.
- `busy`  out  1  high while the FSM is in HOLD.

## Operation
- **Input sync.** Each `irq_extN` passes through two flops (s1, s2) and then a delay flop (s3). The edge term is `s2 & ~s3`.
- **Reset values.** All three flops reset to 0, so a pin held high through reset registers one edge after reset.
- **Timer.** When `TIMER_PERIOD`>0 and `en2`=1, a 16-bit counter runs 0..`TIMER_PERIOD`-1 and wraps.
  - At terminal count it produces a one-cycle tick, ORed with the ext2 edge term.
  - When `en2`=0 the counter holds its value.
  - `reset` loads the counter with 0.
- **Pending set.** An edge (or tick) with `enN`=1 sets `pend[N]` on the next clock.
- **Overrun.** If `pend[N]` is already 1 when an enabled edge arrives, set `ovf[N]`. The pending bit stays 1; requests are not counted.
- **FSM states.** Two states, IDLE and HOLD.
- **IDLE.**
  - If `pend` != 0, on the next edge: select source 1 if `pend[0]`, else source 2.
  - Assert `intrN`=1 for exactly that one cycle, clear `pend[N]`, load hold counter = `HOLDOFF`, go to HOLD.
  - If `pend`=0, stay in IDLE with both `intr` outputs 0.
- **HOLD.** `intr1`=`intr2`=0 and `busy`=1. The counter decrements each cycle; when it reaches 1, go to IDLE on the following edge. New edges are still latched into `pend` during HOLD.
- **Simultaneous set and clear.** If an edge for source N arrives in the same cycle the FSM clears `pend[N]`, set wins: `pend[N]` stays 1 and no overrun is flagged.
- **Simultaneous requests.** Both pending together: source 1 fires first; source 2 fires after the hold-off.
- **Never both outputs.** `intr1` and `intr2` are never high in the same cycle.
- **Reset mid-operation.** On the next edge: state goes to IDLE and all of these clear:
  - outputs (`intr1`, `intr2`, `busy`)
  - `pend` and `ovf`
  - hold counter and timer counter
  - sync flops

## Timing
- Reset values: `intr1`=0, `intr2`=0, `pend`=2'b00, `ovf`=2'b00, `busy`=0, state IDLE.
- **Pin to pending.** A pin rising before clock edge k (setup met) gives s1=1 at k, s2=1 at k+1, and `pend`=1 at k+2.
- **Pending to pulse.** With the FSM idle, `intrN` is high from edge k+3 to k+4. Pin-to-pulse latency is 3 to 4 cycles.
- **Timer to pulse.** A timer tick sets `pend[1]` at the next edge; the pulse follows one edge later when idle.
- **Pulse spacing.** A pulse at cycle t is followed by `busy`=1 for cycles t+1..t+`HOLDOFF`. The earliest next pulse is cycle t+`HOLDOFF`+1.
- **Timer rate.** Ticks occur every `TIMER_PERIOD` cycles while `en2`=1. The first tick comes `TIMER_PERIOD` cycles after `en2` rises from reset state.

## Test plan
- **Single request.** Use `HOLDOFF`=8, `TIMER_PERIOD`=0; after reset, raise `irq_ext1` and hold it.
  - Required: `pend[0]` goes to 1 two edges after capture; exactly one `intr1` pulse at capture+3; `busy` high for 8 cycles; no further pulses.
- **Simultaneous requests.** Raise `irq_ext1` and `irq_ext2` in the same cycle.
  - Required: `intr1` pulse at t, `intr2` pulse at t+9, and the two are never concurrent.
- **Overrun.** Use `en1`=1 and pulse `irq_ext1` three times, 3 cycles apart, during HOLD.
  - Required: one pending pulse after the hold-off; `ovf[0]`=1 and sticky; `ovf[1]`=0.
- **Disabled source.** Use `en2`=0 and toggle `irq_ext2`.
  - Required: `pend[1]`, `intr2`, and `ovf[1]` stay 0; setting `en2`=1 afterwards creates no stale pulse.
- **Timer.** Use `TIMER_PERIOD`=20, `en2`=1, `HOLDOFF`=4.
  - Required: `intr2` pulses exactly every 20 cycles.
  - Dropping `en2` for 5 cycles delays the next pulse by 5 cycles.
- **Reset during HOLD.** Assert `reset` during HOLD with `pend`=2'b10.
  - Required: the next cycle shows all outputs 0, and no pulse follows the release of reset while the pins are low.
